debug_packet_arbiter: RTL

// - Shares one Debug NoC (DII) output link between PORTS packet sources, e.g. the trace

---
 rtl/dii_package.sv | 19 +
 rtl/debug_rr_select.sv | 33 +++
 rtl/debug_packet_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/dii_package.sv
// Shared Debug NoC (DII) flit definition and helpers for the debug interconnect.
package dii_package;

    localparam int unsigned DII_DATA_W   = 16;
    localparam int unsigned DII_FLIT_W   = DII_DATA_W + 2;
    localparam int unsigned DII_LAST_BIT = DII_DATA_W;

    typedef struct packed {
        logic                  valid;
        logic                  last;
        logic [DII_DATA_W-1:0] data;
    } dii_flit;

    // Index width for an N-way selector; never narrower than one bit.
    function automatic int unsigned dii_ptr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debug_rr_select.sv
// Combinational round-robin pick: first requester after ptr, wrapping modulo PORTS.
module debug_rr_select
    import dii_package::*;
#(
    parameter  int unsigned PORTS = 2,
    localparam int unsigned PTR_W = dii_ptr_w(PORTS)
) (
    input  logic [PORTS-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PORTS-1:0] grant_c,
    output logic [PTR_W-1:0] idx_c,
    output logic             any_c
);

    logic [PTR_W-1:0] cand;

    // Scan ptr+1 .. ptr+PORTS; the modulo keeps non-power-of-two sizes in range.
    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        any_c   = 1'b0;
        cand    = '0;
        for (int unsigned k = 1; k <= PORTS; k++) begin
            cand = PTR_W'((32'(ptr) + k) % PORTS);
            if (!any_c && req[cand]) begin
                any_c         = 1'b1;
                grant_c[cand] = 1'b1;
                idx_c         = cand;
            end
        end
    end

endmodule

// File: rtl/debug_packet_arbiter.sv
// Packet-atomic round-robin arbiter sharing one DII link between PORTS sources,
// with a single registered output stage.
module debug_packet_arbiter
    import dii_package::*;
#(
    parameter  int unsigned PORTS = 2,
    localparam int unsigned PTR_W = dii_ptr_w(PORTS)
) (
    input  logic             clk,
    input  logic             rst,
    input  dii_flit          in_flit [PORTS],
    output logic [PORTS-1:0] in_ready,
    output dii_flit          out_flit,
    input  logic             out_ready,
    output logic             busy,
    output logic [PTR_W-1:0] grant_idx
);

    typedef enum logic {
        S_IDLE,
        S_LOCKED
    } state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] grant_q, grant_d;
    logic [PORTS-1:0] grant_oh_q, grant_oh_d;
    logic [PTR_W-1:0] rr_q, rr_d;
    dii_flit          out_q, out_d;

    logic [PORTS-1:0] req;
    logic [PORTS-1:0] pick_oh_c;
    logic [PTR_W-1:0] pick_idx_c;
    logic             pick_any_c;
    dii_flit          sel;
    logic             stage_free_c;
    logic             accept_c;

    always_comb begin
        for (int i = 0; i < int'(PORTS); i++) begin
            req[i] = in_flit[i].valid;
        end
    end

    debug_rr_select #(
        .PORTS (PORTS)
    ) u_rr_select (
        .req     (req),
        .ptr     (rr_q),
        .grant_c (pick_oh_c),
        .idx_c   (pick_idx_c),
        .any_c   (pick_any_c)
    );

    // Flit of the locked source; the one-hot grant makes this a plain AND-OR mux.
    always_comb begin
        sel = '0;
        for (int i = 0; i < int'(PORTS); i++) begin
            if (grant_oh_q[i]) begin
                sel = in_flit[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        grant_oh_d   = grant_oh_q;
        rr_d         = rr_q;
        out_d        = out_q;
        in_ready     = '0;
        accept_c     = 1'b0;
        stage_free_c = ~out_q.valid | out_ready;

        if (out_ready) begin
            out_d.valid = 1'b0;
        end

        case (state_q)
            // Arbitration bubble: pick a source, accept nothing this cycle.
            S_IDLE: begin
                if (pick_any_c) begin
                    grant_d    = pick_idx_c;
                    grant_oh_d = pick_oh_c;
                    rr_d       = pick_idx_c;
                    state_d    = S_LOCKED;
                end
            end
            // Locked until the granted source's last flit is accepted.
            S_LOCKED: begin
                in_ready = grant_oh_q & {PORTS{stage_free_c}};
                accept_c = sel.valid & stage_free_c;
                if (accept_c) begin
                    out_d = '{valid: 1'b1, last: sel.last, data: sel.data};
                    if (sel.last) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            grant_oh_q <= '0;
            rr_q       <= PTR_W'(PORTS - 1);
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_oh_q <= grant_oh_d;
            rr_q       <= rr_d;
            out_q      <= out_d;
        end
    end

    assign out_flit  = out_q;
    assign busy      = (state_q == S_LOCKED);
    assign grant_idx = grant_q;

endmodule
